hp_bar_overlay: RTL
===================

Name: hp_bar_overlay

Overview:
- Parametrised N-player successor of the HP overlay stage in the VGA pixel pipeline. Sits between the game-scene renderer and the mouse/cursor stages.
- Draws one horizontal HP bar per player. Each bar has a decaying "damage trail" (ghost) segment and blinks when HP is low.
- Runs a latched game-end state machine that reports win, loss or draw.
- All timing, mouse and select signals pass through with 1-cycle latency.

Parameters:
- N_PLAYERS, 2, player count; index 0 is the local player.
- HP_W, 8, width of each HP value.
- BAR_X, 810, left x of all bars.
- BAR_Y0, 40, top y of bar 0.
- BAR_H, 16, bar height in lines.
- BAR_PITCH, 30, vertical distance between bar tops.
- LOW_THR, 32, HP at or below this (and >0) blinks.
- BLINK_LOG2, 4, blink half-period = 2^(BLINK_LOG2-1) frames.
- COL_OUR, 12'h3A0, bar colour for player 0.
- COL_ENEMY, 12'hF20, bar colour for players 1..N-1.
- COL_GHOST, 12'hFF0, damage-trail colour.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- hblnk, vblnk, hsync, vsync  in  1 each  timing inputs
- hcount  in  11  horizontal pixel position
- vcount  in  10  vertical pixel position
- rgb  in  12  upstream pixel colour
- xpos_mouse_in, ypos_mouse_in  in  12 each  mouse position
- select  in  1  game screen active
- restart  in  1  clears ENDED state
- hp_state  in  N_PLAYERS*HP_W  packed HP; player i at bits [i*HP_W +: HP_W]
- hblnk_out, vblnk_out, hsync_out, vsync_out, hcount_out, vcount_out, rgb_out, xpos_mouse_out, ypos_mouse_out, select_out  out  matching widths  registered outputs
- game_end  out  2  0=none, 1=player0 won, 2=player0 lost, 3=draw
- winner  out  max(1,clog2(N_PLAYERS))  index of the surviving player; 0 when none or draw

Behaviour:
- Reset (async, rst=1): every output = 0, including xpos/ypos_mouse_out. Ghost registers = 0, frame counter = 0, FSM = IDLE, previous-vblnk register = 0.
- Pipeline: all outputs are registered once. Inputs at cycle t appear at cycle t+1. rgb_out is computed from cycle-t inputs.
- frame_tick: a 1-cycle pulse on the vblnk rising edge (vblnk=1 and prev_vblnk=0).
- Frame counter: BLINK_LOG2 bits, increments on frame_tick, wraps. blink_on = counter MSB==0.
- Ghost per player, updated only on frame_tick:
  - hp > ghost -> ghost = hp (heal is instant).
  - ghost > hp -> ghost decrements by 1.
  - Equal -> hold.
- Bar geometry: bar i occupies lines vcount in [BAR_Y0+i*BAR_PITCH, BAR_Y0+i*BAR_PITCH+BAR_H-1].
- Pixel priority, only when select=1:
  - BAR_X <= hcount < BAR_X+hp[i]: bar colour. If 0<hp<=LOW_THR and blink_on=0, use the rgb passthrough instead.
  - BAR_X+hp[i] <= hcount < BAR_X+ghost[i]: COL_GHOST (never blinks).
  - Otherwise rgb.
  - hp=0 draws no bar pixels. Bar compares use 12-bit arithmetic, no overflow.
  - Overlapping rows: the lowest player index wins.
- select=0: rgb_out = rgb. Ghosts still update.
- alive = number of players with hp != 0, combinational.
- FSM (registered):
  - IDLE -> PLAYING when select=1 and alive=N_PLAYERS.
  - PLAYING -> IDLE when select=0.
  - PLAYING -> ENDED when alive<=1:
    - alive=1 and hp[0]!=0: game_end=1, winner=0.
    - alive=1 and hp[0]=0: game_end=2, winner=index of the survivor.
    - alive=0: game_end=3, winner=0.
  - ENDED holds game_end/winner regardless of later hp or select changes. restart=1 -> IDLE; game_end=0 and winner=0 from the next cycle.
  - restart in IDLE/PLAYING: ignored.
  - Simultaneous select fall and alive<=1 in PLAYING: ENDED takes priority.
  - game_end is 0 in IDLE and PLAYING. game_end and winner update 1 cycle after the deciding hp sample.
- Reset asserted mid-frame or mid-game: immediate return to the reset values. Operation resumes from IDLE.

Test Plan:
- Reset: hold rst with arbitrary inputs -> all outputs 0. Release; at hcount=5, rgb=12'h123 -> rgb_out=12'h123 one cycle later.
- Bar draw: select=1, hp={0:100, 1:50}, ghost settled. Pixel (815,45) -> 12'h3A0. (915,45) -> rgb. (840,75) -> 12'hF20. (860,75) -> rgb.
- Damage trail: hp0 drops 100->90 -> pixel (905,45)=COL_GHOST. After 10 frame_ticks, (905,45)=rgb. Heal 90->100 -> ghost=100 immediately at the next tick.
- Blink: hp0=20 -> (815,45) alternates COL_OUR / rgb every 8 frames. hp0=33 -> never blinks.
- Game end: both alive, select=1 -> PLAYING. hp1=0 -> game_end=1, winner=0 next cycle. Then hp0=0 -> game_end stays 1. restart -> 0.
- Draw and loss: hp0 and hp1 reach 0 in the same cycle -> game_end=3. With N_PLAYERS=3, hp0=hp1=0, hp2=7 -> game_end=2, winner=2.

Source files
------------

// File: rtl/hp_bar_overlay_if.sv
// Video pipeline bundle for the HP bar overlay stage.
// Carries timing, pixel, mouse and screen-select signals.
interface hp_bar_overlay_if;
    logic        hblnk;
    logic        vblnk;
    logic        hsync;
    logic        vsync;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [11:0] rgb;
    logic [11:0] xpos_mouse;
    logic [11:0] ypos_mouse;
    logic        select;

    modport master (
        output hblnk, vblnk, hsync, vsync, hcount, vcount,
        output rgb, xpos_mouse, ypos_mouse, select
    );

    modport slave (
        input hblnk, vblnk, hsync, vsync, hcount, vcount,
        input rgb, xpos_mouse, ypos_mouse, select
    );
endinterface

// File: rtl/hp_bar_overlay.sv
// N-player HP bar overlay with damage trail, low-HP blink
// and a latched game-end state machine.
module hp_bar_overlay #(
    parameter int          N_PLAYERS  = 2,
    parameter int          HP_W       = 8,
    parameter int          BAR_X      = 810,
    parameter int          BAR_Y0     = 40,
    parameter int          BAR_H      = 16,
    parameter int          BAR_PITCH  = 30,
    parameter int          LOW_THR    = 32,
    parameter int          BLINK_LOG2 = 4,
    parameter logic [11:0] COL_OUR    = 12'h3A0,
    parameter logic [11:0] COL_ENEMY  = 12'hF20,
    parameter logic [11:0] COL_GHOST  = 12'hFF0,
    localparam int         WIN_W      = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    hp_bar_overlay_if.slave           in_if,
    hp_bar_overlay_if.master          out_if,
    input  logic                      restart,
    input  logic [N_PLAYERS*HP_W-1:0] hp_state,
    output logic [1:0]                game_end,
    output logic [WIN_W-1:0]          winner
);

    typedef enum logic [1:0] {IDLE, PLAYING, ENDED} state_t;

    state_t                state_q;
    logic [1:0]            game_end_q;
    logic [WIN_W-1:0]      winner_q;
    logic                  prev_vblnk_q;
    logic [BLINK_LOG2-1:0] frame_q;
    logic [HP_W-1:0]       ghost_q [N_PLAYERS];
    logic [HP_W-1:0]       ghost_d [N_PLAYERS];
    logic [HP_W-1:0]       hp      [N_PLAYERS];

    logic        hblnk_q, vblnk_q, hsync_q, vsync_q, select_q;
    logic [10:0] hcount_q;
    logic [9:0]  vcount_q;
    logic [11:0] rgb_q, rgb_d;
    logic [11:0] xpos_q, ypos_q;

    logic             frame_tick;
    logic             blink_on;
    logic [7:0]       alive_c;
    logic [WIN_W-1:0] surv_c;
    logic [11:0]      hc, vc, top, hp_end, gh_end;
    logic             in_row, low;

    assign frame_tick = in_if.vblnk & ~prev_vblnk_q;
    assign blink_on   = ~frame_q[BLINK_LOG2-1];
    assign hc         = {1'b0, in_if.hcount};
    assign vc         = {2'b0, in_if.vcount};

    // Unpack HP, count survivors and remember the highest surviving index.
    always_comb begin
        alive_c = '0;
        surv_c  = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            hp[i] = hp_state[i*HP_W +: HP_W];
            if (hp[i] != '0) begin
                alive_c = alive_c + 8'd1;
                surv_c  = WIN_W'(i);
            end
        end
    end

    // Damage trail: heals jump up, damage drains one step per frame.
    always_comb begin
        for (int i = 0; i < N_PLAYERS; i++) begin
            ghost_d[i] = ghost_q[i];
            if (frame_tick) begin
                if (hp[i] > ghost_q[i])
                    ghost_d[i] = hp[i];
                else if (ghost_q[i] > hp[i])
                    ghost_d[i] = ghost_q[i] - 1'b1;
            end
        end
    end

    // Pixel colour; walk from the last player down so index 0 wins overlaps.
    always_comb begin
        rgb_d  = in_if.rgb;
        top    = '0;
        hp_end = '0;
        gh_end = '0;
        in_row = 1'b0;
        low    = 1'b0;
        if (in_if.select) begin
            for (int i = N_PLAYERS - 1; i >= 0; i--) begin
                top    = 12'(BAR_Y0 + i * BAR_PITCH);
                hp_end = 12'(BAR_X) + 12'(hp[i]);
                gh_end = 12'(BAR_X) + 12'(ghost_q[i]);
                in_row = (vc >= top) && (vc < top + 12'(BAR_H));
                low    = (hp[i] != '0) && (12'(hp[i]) <= 12'(LOW_THR));
                if (in_row) begin
                    if (hc >= 12'(BAR_X) && hc < hp_end) begin
                        if (low && !blink_on)
                            rgb_d = in_if.rgb;
                        else
                            rgb_d = (i == 0) ? COL_OUR : COL_ENEMY;
                    end else if (hc >= hp_end && hc < gh_end) begin
                        rgb_d = COL_GHOST;
                    end
                end
            end
        end
    end

    // Frame edge detect, blink counter and ghost state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_vblnk_q <= 1'b0;
            frame_q      <= '0;
            for (int i = 0; i < N_PLAYERS; i++)
                ghost_q[i] <= '0;
        end else begin
            prev_vblnk_q <= in_if.vblnk;
            if (frame_tick)
                frame_q <= frame_q + 1'b1;
            for (int i = 0; i < N_PLAYERS; i++)
                ghost_q[i] <= ghost_d[i];
        end
    end

    // One-cycle register stage for every pass-through and the pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            select_q <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
            rgb_q    <= '0;
            xpos_q   <= '0;
            ypos_q   <= '0;
        end else begin
            hblnk_q  <= in_if.hblnk;
            vblnk_q  <= in_if.vblnk;
            hsync_q  <= in_if.hsync;
            vsync_q  <= in_if.vsync;
            select_q <= in_if.select;
            hcount_q <= in_if.hcount;
            vcount_q <= in_if.vcount;
            rgb_q    <= rgb_d;
            xpos_q   <= in_if.xpos_mouse;
            ypos_q   <= in_if.ypos_mouse;
        end
    end

    // Game-end FSM; a decided result stays latched until restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            game_end_q <= 2'd0;
            winner_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_if.select && alive_c == 8'(N_PLAYERS))
                        state_q <= PLAYING;
                end
                PLAYING: begin
                    if (alive_c <= 8'd1) begin
                        state_q <= ENDED;
                        if (alive_c == 8'd0) begin
                            game_end_q <= 2'd3;
                            winner_q   <= '0;
                        end else if (hp[0] != '0) begin
                            game_end_q <= 2'd1;
                            winner_q   <= '0;
                        end else begin
                            game_end_q <= 2'd2;
                            winner_q   <= surv_c;
                        end
                    end else if (!in_if.select) begin
                        state_q <= IDLE;
                    end
                end
                ENDED: begin
                    if (restart) begin
                        state_q    <= IDLE;
                        game_end_q <= 2'd0;
                        winner_q   <= '0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    game_end_q <= 2'd0;
                    winner_q   <= '0;
                end
            endcase
        end
    end

    assign out_if.hblnk      = hblnk_q;
    assign out_if.vblnk      = vblnk_q;
    assign out_if.hsync      = hsync_q;
    assign out_if.vsync      = vsync_q;
    assign out_if.hcount     = hcount_q;
    assign out_if.vcount     = vcount_q;
    assign out_if.rgb        = rgb_q;
    assign out_if.xpos_mouse = xpos_q;
    assign out_if.ypos_mouse = ypos_q;
    assign out_if.select     = select_q;
    assign game_end          = game_end_q;
    assign winner            = winner_q;

endmodule
